// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch controller.
//   state_t   : controller states IDLE / RUN / PAUSE
//   bcd_t     : one 4-bit BCD display digit
//   ONES_MAX  : upper limit of a ones digit (9)
//   TENS_MAX  : upper limit of a tens digit (5)
//   digit_inc : wrap-safe digit increment helper
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t ONES_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;

    // Wrapping on ">=" rather than "==" guarantees an out-of-range value can
    // never persist past the next increment.
    function automatic bcd_t digit_inc(input bcd_t d, input bcd_t max);
        return (d >= max) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Two-flop synchronizer, stability-count debouncer and rising-edge detector
// for one raw push-button.
// Parameters:
//   DEBOUNCE_CYCLES : cycles the synchronized level must hold before it is
//                     accepted as the new debounced level
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   raw   : asynchronous raw button level, active-high
//   press : one-cycle pulse on each debounced rising edge
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int DC = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int CW = (DC > 1) ? $clog2(DC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // cnt tracks how many consecutive cycles sync2 has disagreed with
            // the accepted level; the DC-th such cycle flips the level.
            if (sync2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
// MM:SS stopwatch with start/stop, clear and (optional) lap freeze.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze compiled in when set).
// Parameters:
//   TICK_DIV        : clk cycles per one-second tick
//   DEBOUNCE_CYCLES : button debounce stability window in cycles
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   btn_start_stop/btn_clear/btn_lap : raw active-high buttons
//   seconds_ones_counter ... minutes_tens_counter : BCD display digits
//   running                       : high while in RUN
//   lap_active                    : high while the displayed digits are frozen
// -----------------------------------------------------------------------------
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] seconds_ones_counter,
    output logic [3:0] seconds_tens_counter,
    output logic [3:0] minutes_ones_counter,
    output logic [3:0] minutes_tens_counter,
    output logic       running,
    output logic       lap_active
);

    localparam int TD = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int PW = (TD > 1) ? $clog2(TD) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TD - 1);

    logic ss_ev;
    logic clr_ev;
    logic lap_ev;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk(clk), .rst(rst), .raw(btn_start_stop), .press(ss_ev)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .rst(rst), .raw(btn_clear), .press(clr_ev)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(clk), .rst(rst), .raw(btn_lap), .press(lap_ev)
    );

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic          clear_hit;
    bcd_t          so, st, mo, mt;
    logic [15:0]   live;
    logic [15:0]   shown;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Clear is tested before start/stop so a coincident press in PAUSE
    // lands in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_ev) state_next = RUN;
            RUN:     if (ss_ev) state_next = PAUSE;
            PAUSE: begin
                if (clr_ev)     state_next = IDLE;
                else if (ss_ev) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tick      = (state == RUN) && (presc == PRESC_MAX);
    assign clear_hit = (state == PAUSE) && clr_ev;
    assign running   = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else begin
            case (state)
                RUN:     presc <= tick ? '0 : presc + 1'b1;
                PAUSE:   presc <= clear_hit ? '0 : presc;
                default: presc <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_hit) begin
            so <= '0;
            st <= '0;
            mo <= '0;
            mt <= '0;
        end else if (tick) begin
            so <= digit_inc(so, ONES_MAX);
            if (so >= ONES_MAX) begin
                st <= digit_inc(st, TENS_MAX);
                if (st >= TENS_MAX) begin
                    mo <= digit_inc(mo, ONES_MAX);
                    if (mo >= ONES_MAX) begin
                        mt <= digit_inc(mt, TENS_MAX);
                    end
                end
            end
        end
    end

    assign live = {mt, mo, st, so};

`ifdef STOPWATCH_LAP_EN
    logic        lap_on;
    logic [15:0] frozen;

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_on <= 1'b0;
            frozen <= '0;
        end else if (clear_hit) begin
            lap_on <= 1'b0;
        end else if (lap_ev) begin
            if (state == RUN) begin
                if (lap_on) begin
                    lap_on <= 1'b0;
                end else begin
                    lap_on <= 1'b1;
                    frozen <= live;
                end
            end else if (state == PAUSE) begin
                lap_on <= 1'b0;
            end
        end
    end

    assign lap_active = lap_on;
    assign shown      = lap_on ? frozen : live;
`else
    logic unused_lap;

    assign unused_lap = lap_ev;
    assign lap_active = 1'b0;
    assign shown      = live;
`endif

    assign seconds_ones_counter = shown[3:0];
    assign seconds_tens_counter = shown[7:4];
    assign minutes_ones_counter = shown[11:8];
    assign minutes_tens_counter = shown[15:12];

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
// Directed scenarios plus randomized button traffic, checked every cycle
// against an elapsed-seconds reference model.
// Optional feature macro: STOPWATCH_LAP_EN (enables lap scenarios and model).
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

    localparam int TD  = 10;
    localparam int DC  = 4;
    localparam int LAT = DC + 3;  // raw edge to FSM action, in clock edges

    logic       clk = 1'b0;
    logic       rst;
    logic       bss, bclr, blap;
    logic [3:0] so, st, mo, mt;
    logic       running;
    logic       lap_active;

    always #5 clk = ~clk;

    stopwatch_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .btn_start_stop      (bss),
        .btn_clear           (bclr),
        .btn_lap             (blap),
        .seconds_ones_counter(so),
        .seconds_tens_counter(st),
        .minutes_ones_counter(mo),
        .minutes_tens_counter(mt),
        .running             (running),
        .lap_active          (lap_active)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=run 2=pause, elapsed seconds as a plain
    // integer, phase = cycles elapsed inside the current second.
    int m_state, m_phase, m_secs, m_lap, m_frozen;
    int cd_ss, cd_clr, cd_lap;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_secs = 0; m_lap = 0; m_frozen = 0;
        cd_ss = 0; cd_clr = 0; cd_lap = 0;
    endtask

    task automatic model_edge(input bit e_ss, input bit e_clr, input bit e_lap);
        bit tick;
        int ns;
        tick = (m_state == 1) && (m_phase == TD - 1);
        ns   = m_state;
`ifdef STOPWATCH_LAP_EN
        if (m_state == 1 && e_lap) begin
            if (m_lap != 0) m_lap = 0;
            else begin m_lap = 1; m_frozen = m_secs; end
        end else if (m_state == 2 && e_lap) begin
            m_lap = 0;
        end
        if (m_state == 2 && e_clr) m_lap = 0;
`endif
        if (m_state == 2 && e_clr) m_secs = 0;
        else if (tick)             m_secs = (m_secs + 1) % 3600;
        case (m_state)
            1:       m_phase = tick ? 0 : m_phase + 1;
            2:       if (e_clr) m_phase = 0;
            default: m_phase = 0;
        endcase
        case (m_state)
            0: if (e_ss) ns = 1;
            1: if (e_ss) ns = 2;
            default: if (e_clr) ns = 0; else if (e_ss) ns = 1;
        endcase
        m_state = ns;
    endtask

    task automatic step();
        bit e_ss, e_clr, e_lap;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            e_ss = 0; e_clr = 0; e_lap = 0;
            if (cd_ss  > 0) begin cd_ss--;  e_ss  = (cd_ss  == 0); end
            if (cd_clr > 0) begin cd_clr--; e_clr = (cd_clr == 0); end
            if (cd_lap > 0) begin cd_lap--; e_lap = (cd_lap == 0); end
            model_edge(e_ss, e_clr, e_lap);
        end
        #1;
        check("digits", {mt, mo, st, so}, (m_lap != 0) ? to_bcd(m_frozen) : to_bcd(m_secs));
        check("running", running, (m_state == 1));
        check("lap_active", lap_active, (m_lap != 0));
    endtask

    task automatic raise(input bit s, input bit c, input bit l);
        if (s) begin bss  = 1'b1; cd_ss  = LAT; end
        if (c) begin bclr = 1'b1; cd_clr = LAT; end
        if (l) begin blap = 1'b1; cd_lap = LAT; end
    endtask

    task automatic lower_all();
        bss = 1'b0; bclr = 1'b0; blap = 1'b0;
    endtask

    task automatic press(input bit s, input bit c, input bit l, input int hold, input int low);
        raise(s, c, l);
        repeat (hold) step();
        lower_all();
        repeat (low) step();
    endtask

    task automatic glitch(input int which, input int toggles);
        for (int i = 0; i < toggles; i++) begin
            case (which)
                0:       bss  = ~bss;
                1:       bclr = ~bclr;
                default: blap = ~blap;
            endcase
            repeat (2) step();
        end
        lower_all();
        repeat (8) step();
    endtask

    task automatic run_until(input int s, input int p);
        int n;
        n = 0;
        while (!(m_secs == s && m_phase == p && m_state == 1) && n < 50000) begin
            step();
            n++;
        end
        if (n >= 50000) begin
            checks++;
            failures++;
            $display("FAIL run_until_timeout got=%0d exp=%0d", m_secs, s);
        end
    endtask

    initial begin
        logic [2:0] m;
        model_reset();
        rst = 1'b1;
        lower_all();
        repeat (3) step();
        check("reset_digits", {mt, mo, st, so}, 16'h0000);
        check("reset_running", running, 1'b0);
        check("reset_lap", lap_active, 1'b0);
        rst = 1'b0;
        step();

        // Start held 10 cycles: running rises on the 7th edge.
        raise(1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) check("start_early", running, 1'b0);
            if (k == 7) check("start_latency", running, 1'b1);
        end
        lower_all();
        run_until(10, 0);
        check("ten_ticks", {mt, mo, st, so}, 16'h0010);
        run_until(600, 0);
        check("ten_minutes", {mt, mo, st, so}, 16'h1000);
        run_until(0, 0);
        check("hour_wrap", {mt, mo, st, so}, 16'h0000);
        check("hour_wrap_running", running, 1'b1);

        // Clear while running is ignored.
        press(0, 1, 0, 8, 8);
        check("clear_in_run", running, 1'b1);

        // Pause at 00:05 with the prescaler left at 6.
        run_until(4, 9);
        raise(1, 0, 0);
        repeat (LAT) step();
        check("paused", running, 1'b0);
        repeat (2) step();
        lower_all();
        repeat (100) step();
        check("pause_hold", {mt, mo, st, so}, 16'h0005);

        // Resume: partial second preserved, next tick 4 cycles after re-entry.
        raise(1, 0, 0);
        repeat (LAT) step();
        check("resumed", running, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) check("resume_pre_tick", {mt, mo, st, so}, 16'h0005);
            if (k == 4) check("resume_tick", {mt, mo, st, so}, 16'h0006);
        end
        lower_all();
        repeat (8) step();

        // Pause, then clear and start together: clear wins.
        press(1, 0, 0, 8, 8);
        press(1, 1, 0, 8, 8);
        check("clr_ss_digits", {mt, mo, st, so}, 16'h0000);
        check("clr_ss_running", running, 1'b0);

        // Bouncing start button produces no event.
        glitch(0, 10);
        repeat (12) step();
        check("glitch_idle", running, 1'b0);

`ifdef STOPWATCH_LAP_EN
        press(1, 0, 0, 8, 0);
        run_until(3, 0);
        raise(0, 0, 1);
        repeat (LAT) step();
        check("lap_on", lap_active, 1'b1);
        repeat (2) step();
        lower_all();
        run_until(8, 0);
        check("lap_frozen", {mt, mo, st, so}, 16'h0003);
        check("lap_still_on", lap_active, 1'b1);
        raise(0, 0, 1);
        repeat (LAT) step();
        check("lap_release", {mt, mo, st, so}, 16'h0008);
        check("lap_off", lap_active, 1'b0);
        repeat (2) step();
        lower_all();
        repeat (8) step();
`endif

        // Randomized button traffic against the model.
        for (int op = 0; op < 250; op++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: repeat ($urandom_range(1, 40)) step();
                3, 4, 5, 6: begin
                    m = 3'($urandom_range(1, 7));
                    press(m[0], m[1], m[2], $urandom_range(6, 12), $urandom_range(7, 15));
                end
                7: glitch($urandom_range(0, 2), $urandom_range(4, 10));
                8: press(1, 0, 0, $urandom_range(6, 12), $urandom_range(7, 15));
                default: begin
                    rst = 1'b1;
                    repeat ($urandom_range(1, 3)) step();
                    rst = 1'b0;
                    step();
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
